uc_arbiter: RTL and testbench
=============================

Name: uc_arbiter

Overview:
- Unit Clause Arbiter (uca). Sits directly upstream of the unit clause queue (ucq).
- Collects unit-clause literals produced by N_ENG process engines and round-robin arbitrates among them.
- Suppresses literals already enqueued since the last flush, then pushes at most one literal per cycle into the ucq through a one-entry registered output stage.

Parameters:
- N_ENG, 4, number of requesting process engines.
- UC_LEN, `UC_LENGTH, literal space size; LIT_W = $clog2(UC_LEN).
- DROP_CNT_W, 16, width of the saturating duplicate-drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  clears the dedup bitmap and output stage; starts a new problem/decision level.
- eng_req  in  N_ENG  per-engine request; literal valid.
- eng_lit  in  N_ENG x LIT_W  per-engine literal index.
- eng_gnt  out  N_ENG  one-hot acknowledge; the engine's literal is consumed this cycle.
- ucq_full  in  1  full flag from the unit clause queue.
- uca_push  out  1  push strobe to the queue.
- uca2ucq  out  LIT_W  literal to the queue.
- drop_cnt  out  DROP_CNT_W  number of duplicates dropped since reset/flush; saturating.

Behaviour:
- Reset (rst=0, async): out_valid=0, out_lit=0, bitmap=0, rr_ptr=0, drop_cnt=0. Outputs: uca_push=0, uca2ucq=0, eng_gnt=0.
- Output stage:
  - uca_push = out_valid & ~ucq_full (combinational).
  - uca2ucq = out_lit.
  - The stage is "free" when out_valid=0 or uca_push=1.
- Arbitration (combinational):
  - When free and not flush, grant the first requesting engine at or after rr_ptr, wrapping modulo N_ENG.
  - eng_gnt is one-hot or zero. No grant when not free or when flush=1.
- On a grant to engine i with literal L (registered at the next edge):
  - rr_ptr <= (i+1) mod N_ENG.
  - If bitmap[L]=0: bitmap[L]<=1, out_lit<=L, out_valid<=1.
  - If bitmap[L]=1: the duplicate is dropped. The engine is still granted. drop_cnt increments, saturating at all-ones.
  - out_valid <= 0 if the stage emptied via uca_push with a drop or no grant in the same cycle.
- Latency: a literal granted at cycle t appears with uca_push at t+1 if ucq_full=0. Sustained throughput is 1 literal/cycle while not full.
- Backpressure: while ucq_full=1 with out_valid=1, out_lit holds stable, no grants are issued, and requests stay pending. Engines must hold eng_req/eng_lit until granted.
- Flush has priority over everything:
  - Next edge: bitmap<=0, out_valid<=0, drop_cnt<=0.
  - uca_push is still asserted combinationally in the flush cycle if the pending literal can push. That literal is accepted by the queue.
  - rr_ptr is retained.
- Simultaneous requests with the same literal: only one is granted per cycle. The later one is dropped as a duplicate when granted.
- rr_ptr wrap: the engine at N_ENG-1 is followed by engine 0.
- Literal index outside UC_LEN is illegal. The assertion fires in simulation; hardware behaviour is don't-care.

Decomposition:
- Shared package uc_pkg: LIT_W derivation, a literal typedef uc_lit_t, and N_ENG default constant. ucq and engines reuse these.
- One natural sub-module: rr_arbiter (N-way round-robin, req/ptr in -> one-hot gnt). Reusable elsewhere, e.g. queue-to-engine dispatch.
- The bitmap and output register stay inline.

Test Plan:
1. Reset/idle: rst=0 mid-push with out_valid=1 -> uca_push=0, eng_gnt=0, drop_cnt=0 immediately (async); after release, no activity without requests.
2. Round-robin fairness: N_ENG=4, all req continuously with literals 1,2,3,4, ucq_full=0 -> grants 0,1,2,3 on consecutive cycles; uca2ucq sequence 1,2,3,4 starting one cycle later; rr_ptr wraps to 0.
3. Dedup: engine0 sends 5, then engine2 sends 5 -> one push of 5; second grant produces no push; drop_cnt=1.
4. Backpressure: out_lit=7 pending, ucq_full=1 for 3 cycles with engine1 requesting 9 -> uca2ucq stays 7, eng_gnt=0 for 3 cycles; then push 7, grant 9, push 9 the next cycle.
5. Flush: bitmap holds {3}, assert flush for 1 cycle, then engine0 sends 3 -> 3 is pushed again; drop_cnt=0.
6. Saturation: DROP_CNT_W=2, 5 duplicate grants -> drop_cnt sticks at 3.

Source files
------------

// File: rtl/uc_arbiter_pkg.sv
// Shared unit-clause definitions: literal width derivation, literal type and
// engine-count default, reused by the arbiter, the queue and the engines.
`ifndef UC_LENGTH
`define UC_LENGTH 64
`endif

package uc_pkg;
  localparam int N_ENG_DEF  = 4;
  localparam int UC_LEN_DEF = `UC_LENGTH;
  localparam int LIT_W_DEF  = $clog2(UC_LEN_DEF);

  typedef logic [LIT_W_DEF-1:0] uc_lit_t;

  // Round-robin successor of idx among n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/uc_arbiter_if.sv
// Engine request bus plus the push port toward the unit clause queue.
interface uc_arbiter_if #(
  parameter int N_ENG = 4,
  parameter int LIT_W = 6
);
  logic [N_ENG-1:0]            eng_req;
  logic [N_ENG-1:0][LIT_W-1:0] eng_lit;
  logic [N_ENG-1:0]            eng_gnt;
  logic                        ucq_full;
  logic                        uca_push;
  logic [LIT_W-1:0]            uca2ucq;

  modport slave  (input eng_req, eng_lit, ucq_full, output eng_gnt, uca_push, uca2ucq);
  modport master (output eng_req, eng_lit, ucq_full, input eng_gnt, uca_push, uca2ucq);
endinterface

// File: rtl/uc_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Output is one-hot or zero.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: round-robin picks one engine literal per cycle, drops
// literals already seen since the last flush, and feeds a one-entry output stage.
module uc_arbiter
  import uc_pkg::*;
#(
  parameter int N_ENG      = N_ENG_DEF,
  parameter int UC_LEN     = UC_LEN_DEF,
  parameter int DROP_CNT_W = 16,
  localparam int LIT_W     = $clog2(UC_LEN),
  localparam int PW        = (N_ENG > 1) ? $clog2(N_ENG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  uc_arbiter_if.slave           bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  logic              out_valid;
  logic [LIT_W-1:0]  out_lit;
  logic [UC_LEN-1:0] bitmap;
  logic [PW-1:0]     rr_ptr;

  logic              push, free, g_any, dup, lit_ok;
  logic [N_ENG-1:0]  arb_req, gnt;
  logic [PW-1:0]     g_idx;
  logic [LIT_W-1:0]  g_lit;

  assign push = out_valid & ~bus.ucq_full;
  assign free = ~out_valid | push;
  // rst gating keeps grants quiet while reset is held, even with requests up.
  assign arb_req = bus.eng_req & {N_ENG{free & ~flush & rst}};

  rr_arbiter #(.N(N_ENG), .PW(PW)) u_rr (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    g_idx = '0;
    g_lit = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (gnt[i]) begin
        g_idx = PW'(i);
        g_lit = bus.eng_lit[i];
      end
    end
  end

  assign g_any  = |gnt;
  assign dup    = bitmap[g_lit];
  assign lit_ok = 32'(g_lit) < 32'(UC_LEN);

  assign bus.eng_gnt  = gnt;
  assign bus.uca_push = push;
  assign bus.uca2ucq  = out_lit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_lit   <= '0;
      bitmap    <= '0;
      rr_ptr    <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      // A literal pushing in the flush cycle is taken by the queue; rr_ptr survives.
      bitmap    <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) out_valid <= 1'b0;
      if (g_any) begin
        rr_ptr <= PW'(rr_next(int'(g_idx), N_ENG));
        if (!dup) begin
          bitmap[g_lit] <= 1'b1;
          out_lit       <= g_lit;
          out_valid     <= 1'b1;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  a_lit_range: assert property (@(posedge clk) disable iff (!rst) g_any |-> lit_ok);
endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: directed vector table, async reset
// sequence, then randomized traffic against a behavioural model.
module tb_uc_arbiter;
  localparam int N = 4, LW = 4, UL = 16, DW = 2;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic [DW-1:0] drop_cnt;

  uc_arbiter_if #(.N_ENG(N), .LIT_W(LW)) bus();

  uc_arbiter #(.N_ENG(N), .UC_LEN(UL), .DROP_CNT_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic fl, input logic [3:0] rq, input logic [15:0] lt, input logic fu);
    flush        = fl;
    bus.eng_req  = rq;
    bus.eng_lit  = lt;
    bus.ucq_full = fu;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // eng_lit packs one hex digit per engine: engine e in bits [4e+3:4e].
  typedef struct {
    logic        fl;
    logic [3:0]  rq;
    logic [15:0] lt;
    logic        fu;
    logic [3:0]  gnt;
    logic        push;
    int          out;
    int          drop;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic fl, input logic [3:0] rq, input logic [15:0] lt,
                             input logic fu, input logic [3:0] g, input logic p,
                             input int o, input int d);
    vec_t r;
    r.fl = fl; r.rq = rq; r.lt = lt; r.fu = fu;
    r.gnt = g; r.push = p; r.out = o; r.drop = d;
    return r;
  endfunction

  // Reference model state
  bit seen[UL];
  bit pv;
  int pl, ptr, drops;

  initial begin
    logic [3:0]  rq;
    logic [15:0] lt;
    logic        fl, fu, e_push, e_free;
    int          gi, e;

    // round robin
    tv.push_back(v(0, 4'hF, 16'h4321, 0, 4'b0001, 0, 0, 0));
    tv.push_back(v(0, 4'hF, 16'h4321, 0, 4'b0010, 1, 1, 0));
    tv.push_back(v(0, 4'hF, 16'h4321, 0, 4'b0100, 1, 2, 0));
    tv.push_back(v(0, 4'hF, 16'h4321, 0, 4'b1000, 1, 3, 0));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 1, 4, 0));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 0, 4, 0));
    // dedup: eng0 then eng2 both send 5
    tv.push_back(v(0, 4'b0001, 16'h0005, 0, 4'b0001, 0, 4, 0));
    tv.push_back(v(0, 4'b0100, 16'h0500, 0, 4'b0100, 1, 5, 0));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 0, 5, 1));
    // backpressure: 7 pending, queue full 3 cycles, eng1 waits with 9
    tv.push_back(v(0, 4'b0001, 16'h0007, 0, 4'b0001, 0, 5, 1));
    tv.push_back(v(0, 4'b0010, 16'h0090, 1, 4'b0000, 0, 7, 1));
    tv.push_back(v(0, 4'b0010, 16'h0090, 1, 4'b0000, 0, 7, 1));
    tv.push_back(v(0, 4'b0010, 16'h0090, 1, 4'b0000, 0, 7, 1));
    tv.push_back(v(0, 4'b0010, 16'h0090, 0, 4'b0010, 1, 7, 1));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 1, 9, 1));
    // flush then 3 again
    tv.push_back(v(1, 4'h0, 16'h0000, 0, 4'b0000, 0, 9, 1));
    tv.push_back(v(0, 4'b0001, 16'h0003, 0, 4'b0001, 0, 9, 0));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 1, 3, 0));
    // saturation: repeated duplicates of 3
    tv.push_back(v(0, 4'b0001, 16'h0003, 0, 4'b0001, 0, 3, 0));
    tv.push_back(v(0, 4'b0010, 16'h0030, 0, 4'b0010, 0, 3, 1));
    tv.push_back(v(0, 4'b0010, 16'h0030, 0, 4'b0010, 0, 3, 2));
    tv.push_back(v(0, 4'b0010, 16'h0030, 0, 4'b0010, 0, 3, 3));
    tv.push_back(v(0, 4'b0010, 16'h0030, 0, 4'b0010, 0, 3, 3));
    tv.push_back(v(0, 4'b0010, 16'h0030, 0, 4'b0010, 0, 3, 3));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 0, 3, 3));
    // flush with a pending literal that pushes in the flush cycle
    tv.push_back(v(0, 4'b0001, 16'h0008, 0, 4'b0001, 0, 3, 3));
    tv.push_back(v(1, 4'b0010, 16'h0080, 0, 4'b0000, 1, 8, 3));
    tv.push_back(v(0, 4'b0010, 16'h0080, 0, 4'b0010, 0, 8, 0));
    tv.push_back(v(0, 4'h0, 16'h0000, 0, 4'b0000, 1, 8, 0));
    // set up a pending push for the async reset check
    tv.push_back(v(0, 4'b0001, 16'h0008, 0, 4'b0001, 0, 8, 0));
    tv.push_back(v(0, 4'b0010, 16'h00A0, 0, 4'b0010, 0, 8, 1));

    drive(0, 4'h0, 16'h0, 0);
    @(negedge clk); @(negedge clk);
    chk("rst_push", int'(bus.uca_push), 0);
    chk("rst_gnt",  int'(bus.eng_gnt), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_lit",  int'(bus.uca2ucq), 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tv[i]) begin
      drive(tv[i].fl, tv[i].rq, tv[i].lt, tv[i].fu);
      #1;
      chk($sformatf("tv%0d_gnt", i),  int'(bus.eng_gnt),  int'(tv[i].gnt));
      chk($sformatf("tv%0d_push", i), int'(bus.uca_push), int'(tv[i].push));
      chk($sformatf("tv%0d_lit", i),  int'(bus.uca2ucq),  tv[i].out);
      chk($sformatf("tv%0d_drop", i), int'(drop_cnt),     tv[i].drop);
      tick();
    end

    // Async reset while 10 is pushing and engine 0 is requesting
    drive(0, 4'b0001, 16'h000B, 0);
    #1;
    chk("pre_rst_push", int'(bus.uca_push), 1);
    rst = 1'b0;
    #1;
    chk("arst_push", int'(bus.uca_push), 0);
    chk("arst_gnt",  int'(bus.eng_gnt), 0);
    chk("arst_drop", int'(drop_cnt), 0);
    chk("arst_lit",  int'(bus.uca2ucq), 0);
    @(negedge clk);
    drive(0, 4'h0, 16'h0, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idle_push", int'(bus.uca_push), 0);
      chk("idle_gnt",  int'(bus.eng_gnt), 0);
      chk("idle_drop", int'(drop_cnt), 0);
      tick();
    end

    // Randomized traffic against the model (state now equals post-reset)
    foreach (seen[k]) seen[k] = 1'b0;
    pv = 1'b0; pl = 0; ptr = 0; drops = 0;
    rq = '0; lt = '0;
    for (int c = 0; c < 3000; c++) begin
      fl = ($urandom_range(0, 31) == 0);
      fu = ($urandom_range(0, 3) == 0);
      drive(fl, rq, lt, fu);
      #1;
      e_push = pv && !fu;
      e_free = !pv || e_push;
      gi = -1;
      if (e_free && !fl)
        for (int k = 0; k < N; k++) begin
          e = (ptr + k) % N;
          if (gi < 0 && rq[e]) gi = e;
        end
      chk("rnd_gnt",  int'(bus.eng_gnt), (gi >= 0) ? (1 << gi) : 0);
      chk("rnd_push", int'(bus.uca_push), int'(e_push));
      chk("rnd_lit",  int'(bus.uca2ucq), pl);
      chk("rnd_drop", int'(drop_cnt), drops);
      if (fl) begin
        foreach (seen[k]) seen[k] = 1'b0;
        pv = 1'b0;
        drops = 0;
      end else begin
        if (e_push) pv = 1'b0;
        if (gi >= 0) begin
          ptr = (gi + 1) % N;
          e = int'(lt[gi*4 +: 4]);
          if (seen[e]) begin
            if (drops < (1 << DW) - 1) drops++;
          end else begin
            seen[e] = 1'b1;
            pl = e;
            pv = 1'b1;
          end
        end
      end
      tick();
      if (gi >= 0) rq[gi] = 1'b0;
      for (int k = 0; k < N; k++)
        if (!rq[k] && $urandom_range(0, 1) == 1) begin
          rq[k] = 1'b1;
          lt[k*4 +: 4] = 4'($urandom_range(0, UL - 1));
        end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
